coherence_bus_ctrl: RTL and testbench
=====================================

Name: coherence_bus_ctrl

Overview:
- Shared-memory bus controller downstream of both cores' icache and dcache. Arbitrates their requests onto a single RAM port.
- Services data reads with snooping: it probes the other core's dcache, then sources the word either cache-to-cache or from RAM.
- All per-core buses are flattened as [1:0] arrays; index 0 = core 0.

Parameters:
- CPUS, 2, number of cores. Fixed at 2; the round-robin logic depends on it.
- SNOOP_CYC, 1, cycles ccwait is held before ccwrite is sampled.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- iREN  in  2  instruction read request per core
- iaddr  in  2x32  instruction address per core
- iwait  out  2  instruction stall (low = iload valid this cycle)
- iload  out  2x32  instruction data
- dREN, dWEN  in  2 each  data read / write request per core
- daddr, dstore  in  2x32 each  data address / write data (dstore also carries snoop responses)
- dwait  out  2  data stall (low = access complete)
- dload  out  2x32  data read result
- ccwrite  in  2  snoop hit from the snooped core; on the requester side, write intent
- cctrans  in  2  requester marks a coherence transaction
- ccwait  out  2  snoop in progress; the target must answer on ccwrite/dstore
- ccinv  out  2  invalidate the snooped block
- ccsnoopaddr  out  2x32  snoop address
- ramREN, ramWEN  out  1 each  RAM read / write strobe
- ramaddr, ramstore  out  32 each  RAM address / write data
- ramload  in  32  RAM read data
- ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR

Behaviour:
- Reset values and combinational defaults:
  - iwait = dwait = 2'b11.
  - ccwait, ccinv, iload, dload, ccsnoopaddr, all ram* outputs = 0.
  - State = IDLE, owner = 0, rr (last-granted core) = 1.
- State registers:
  - state: IDLE, SNOOP, C2C, RAMRD, WB, IFETCH.
  - owner: 1 bit, the core being served.
  - rr: 1 bit.
  - snoop counter.
- Grant in IDLE, class priority (highest first):
  - dWEN goes to WB.
  - dREN goes to SNOOP.
  - iREN goes to IFETCH.
- Within a class, if both cores request, grant core !rr. Otherwise grant the single requester.
- On grant: latch owner, set rr = owner. No outputs are asserted in the grant cycle.
- Let s = !owner throughout.
- SNOOP:
  - ccwait[s] = 1, ccsnoopaddr[s] = daddr[owner], ccinv[s] = cctrans[owner] & ccwrite[owner].
  - Hold for SNOOP_CYC cycles, then sample ccwrite[s].
  - ccwrite[s] = 1 goes to C2C; otherwise to RAMRD.
- C2C:
  - ccwait[s] held.
  - ramWEN = 1, ramaddr = daddr[owner], ramstore = dstore[s] (write-through keeps RAM coherent).
  - When ramstate == ACCESS: dwait[owner] = 0, dload[owner] = dstore[s], then go to IDLE.
- RAMRD:
  - ccwait[s] held.
  - ramREN = 1, ramaddr = daddr[owner].
  - When ACCESS: dwait[owner] = 0, dload[owner] = ramload, then go to IDLE.
- WB:
  - ramWEN = 1, ramaddr = daddr[owner], ramstore = dstore[owner].
  - No snoop.
  - When ACCESS: dwait[owner] = 0, then go to IDLE.
- IFETCH:
  - ramREN = 1, ramaddr = iaddr[owner].
  - When ACCESS: iwait[owner] = 0, iload[owner] = ramload, then go to IDLE.
- ramstate BUSY, FREE or ERROR: stay in the current state and keep stalling. ERROR is treated as BUSY.
- Completion signals are single-cycle pulses. The controller returns to IDLE one cycle after every completion.
- The core requesting that class may deassert its request before completion. In that case, return to IDLE next cycle with no ack and no RAM strobe.
- Data paths move one word per transaction. A dcache two-word block takes two transactions.
- ccwait never asserts on the owner. The non-owner's requests wait until owner completes.
- Latency, RAM ACCESS on first cycle, SNOOP_CYC = 1:
  - Data read: request at cycle 0, dwait low at cycle 3.
  - Write and ifetch: dwait/iwait low at cycle 2.
- Reset mid-transaction: immediate return to IDLE. All strobes deassert asynchronously.

Test Plan:
1. Core 0 iREN, iaddr = 0x40, ramload = 0x8C010004, ramstate = ACCESS → iwait[0] low at cycle 2, iload[0] = 0x8C010004, ramaddr = 0x40.
2. Core 1 dREN, daddr = 0x100, ccwrite[0] = 0 → ccwait[0] = 1 and ccsnoopaddr[0] = 0x100 at cycle 1; RAMRD; dload[1] = ramload at cycle 3.
3. Core 0 dREN, daddr = 0x200, cctrans[0] = ccwrite[0] = 1, core 1 answers ccwrite[1] = 1, dstore[1] = 0xDEADBEEF → ccinv[1] = 1; C2C with ramWEN = 1, ramstore = 0xDEADBEEF; dload[0] = 0xDEADBEEF.
4. Both cores dWEN in the same cycle after reset (rr = 1) → core 0 served first; core 1 next; a subsequent tie grants core 0 again.
5. Core 0 dWEN while core 1 iREN, ramstate = BUSY for 4 cycles → WB wins; dwait[0] low on the first ACCESS cycle; only then is IFETCH granted to core 1.
6. nRST pulsed during RAMRD → all outputs return to defaults immediately; the same request re-issued completes normally.

Source files
------------

// File: rtl/coherence_bus_ctrl.sv
// Two-core coherent memory bus controller.
// Arbitrates icache/dcache requests onto one RAM port and snoops data reads.
module coherence_bus_ctrl #(
    parameter int CPUS      = 2,
    parameter int SNOOP_CYC = 1
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [CPUS-1:0]       iREN,
    input  logic [CPUS-1:0][31:0] iaddr,
    output logic [CPUS-1:0]       iwait,
    output logic [CPUS-1:0][31:0] iload,
    input  logic [CPUS-1:0]       dREN,
    input  logic [CPUS-1:0]       dWEN,
    input  logic [CPUS-1:0][31:0] daddr,
    input  logic [CPUS-1:0][31:0] dstore,
    output logic [CPUS-1:0]       dwait,
    output logic [CPUS-1:0][31:0] dload,
    input  logic [CPUS-1:0]       ccwrite,
    input  logic [CPUS-1:0]       cctrans,
    output logic [CPUS-1:0]       ccwait,
    output logic [CPUS-1:0]       ccinv,
    output logic [CPUS-1:0][31:0] ccsnoopaddr,
    output logic                  ramREN,
    output logic                  ramWEN,
    output logic [31:0]           ramaddr,
    output logic [31:0]           ramstore,
    input  logic [31:0]           ramload,
    input  logic [1:0]            ramstate
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam int CW = (SNOOP_CYC > 1) ? $clog2(SNOOP_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SNOOP_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        SNOOP,
        C2C,
        RAMRD,
        WB,
        IFETCH
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          rr_q, rr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // ACCESS only counts once the RAM has seen our strobe for a full
    // cycle, so a stale ACCESS left over from the previous
    // transaction can never complete this one.
    logic          arm_q, arm_d;

    logic            s;
    logic            req_ok;
    logic            acc;
    logic [CPUS-1:0] cls;
    logic            pick;

    assign s   = ~owner_q;
    assign acc = arm_q && (ramstate == RAM_ACCESS);

    // Highest-priority request class and the core granted within it
    always_comb begin
        if (|dWEN) begin
            cls = dWEN;
        end else if (|dREN) begin
            cls = dREN;
        end else begin
            cls = iREN;
        end
        pick = (&cls) ? ~rr_q : cls[1];
    end

    // Owner still wants the transaction of the class being served
    always_comb begin
        req_ok = 1'b0;
        unique case (state_q)
            SNOOP, C2C, RAMRD: req_ok = dREN[owner_q];
            WB:                req_ok = dWEN[owner_q];
            IFETCH:            req_ok = iREN[owner_q];
            default:           req_ok = 1'b0;
        endcase
    end

    // Bus, snoop and completion outputs decoded from the current state
    always_comb begin
        iwait       = '1;
        dwait       = '1;
        iload       = '0;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        if (req_ok) begin
            unique case (state_q)
                SNOOP: begin
                    ccwait[s]      = 1'b1;
                    ccsnoopaddr[s] = daddr[owner_q];
                    ccinv[s]       = cctrans[owner_q] & ccwrite[owner_q];
                end
                C2C: begin
                    ccwait[s] = 1'b1;
                    ramWEN    = 1'b1;
                    ramaddr   = daddr[owner_q];
                    ramstore  = dstore[s];
                    if (acc) begin
                        dwait[owner_q] = 1'b0;
                        dload[owner_q] = dstore[s];
                    end
                end
                RAMRD: begin
                    ccwait[s] = 1'b1;
                    ramREN    = 1'b1;
                    ramaddr   = daddr[owner_q];
                    if (acc) begin
                        dwait[owner_q] = 1'b0;
                        dload[owner_q] = ramload;
                    end
                end
                WB: begin
                    ramWEN   = 1'b1;
                    ramaddr  = daddr[owner_q];
                    ramstore = dstore[owner_q];
                    if (acc) begin
                        dwait[owner_q] = 1'b0;
                    end
                end
                IFETCH: begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr[owner_q];
                    if (acc) begin
                        iwait[owner_q] = 1'b0;
                        iload[owner_q] = ramload;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state: grant in IDLE, snoop timing, completion and abort
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        arm_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (|dWEN) begin
                    state_d = WB;
                end else if (|dREN) begin
                    state_d = SNOOP;
                end else if (|iREN) begin
                    state_d = IFETCH;
                end
                if (|cls) begin
                    owner_d = pick;
                    rr_d    = pick;
                end
            end
            SNOOP: begin
                if (!req_ok) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ccwrite[s] ? C2C : RAMRD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            C2C, RAMRD, WB, IFETCH: begin
                if (!req_ok || acc) begin
                    state_d = IDLE;
                end else begin
                    arm_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset drops every strobe immediately
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            rr_q    <= 1'b1;
            cnt_q   <= '0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            arm_q   <= arm_d;
        end
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Scoreboard bench for coherence_bus_ctrl.
// Transaction-level model predicts grant order, data and RAM effects.
module tb_coherence_bus_ctrl;

    localparam logic [1:0] RS_BUSY = 2'd1;
    localparam logic [1:0] RS_ACC  = 2'd2;

    logic             CLK = 1'b0;
    logic             nRST;
    logic [1:0]       iREN, dREN, dWEN, cctrans, ccwrite;
    logic [1:0][31:0] iaddr, daddr, dstore;
    logic [1:0]       iwait, dwait, ccwait, ccinv;
    logic [1:0][31:0] iload, dload, ccsnoopaddr;
    logic             ramREN, ramWEN;
    logic [31:0]      ramaddr, ramstore, ramload;
    logic [1:0]       ramstate;

    always #5 CLK = ~CLK;

    coherence_bus_ctrl #(.CPUS(2), .SNOOP_CYC(1)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ccwrite(ccwrite), .cctrans(cctrans), .ccwait(ccwait),
        .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    typedef struct {
        int          core;
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        bit          hit;
        bit          inv;
        int          lat;
        int          t0;
    } item_t;

    item_t            exq[$];
    int               checks = 0;
    int               failures = 0;
    int               cyc = 0;
    int               rr_m = 1;
    int               ack_cnt[2] = '{0, 0};
    int               seen[2] = '{0, 0};
    int               busy_left = 0;
    bit               rand_ram = 1'b0;
    logic [31:0]      ram[64];
    logic [31:0]      refmem[64];
    logic [1:0]       hit, intent;
    logic [1:0][31:0] snoopval, wdata;

    assign ccwrite   = (ccwait & hit) | (~ccwait & intent);
    assign dstore[0] = ccwait[0] ? snoopval[0] : wdata[0];
    assign dstore[1] = ccwait[1] ? snoopval[1] : wdata[1];
    assign ramload   = ram[ramaddr[7:2]];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Monitor: snoop probes and completions against the queue head
    initial begin
        item_t it;
        forever begin
            @(negedge CLK);
            if (nRST === 1'b1) begin
                for (int c = 0; c < 2; c++) begin
                    if (ccwait[c]) begin
                        if (exq.size() == 0) begin
                            chk("stray_ccwait", 32'(c), 32'hFFFFFFFF);
                        end else begin
                            chk("snoop_kind", 32'(exq[0].kind), 32'd1);
                            chk("snoop_target", 32'(c), 32'(1 - exq[0].core));
                            if (!ramREN && !ramWEN) begin
                                chk("snoop_addr", ccsnoopaddr[c], exq[0].addr);
                                chk("snoop_inv", 32'(ccinv[c]), 32'(exq[0].inv));
                            end else begin
                                chk("inv_after_snoop", 32'(ccinv[c]), 32'd0);
                            end
                        end
                    end
                end
                for (int c = 0; c < 2; c++) begin
                    if (!iwait[c] || !dwait[c]) begin
                        if (exq.size() == 0) begin
                            chk("stray_ack", 32'(c), 32'hFFFFFFFF);
                        end else begin
                            it = exq.pop_front();
                            chk("ack_core", 32'(c), 32'(it.core));
                            chk("ack_class", 32'({~iwait[c], ~dwait[c]}),
                                (it.kind == 0) ? 32'd2 : 32'd1);
                            chk("ack_ramaddr", ramaddr, it.addr);
                            if (it.kind == 0) begin
                                chk("iload", iload[c], it.data);
                                chk("if_strobe", 32'({ramREN, ramWEN}), 32'd2);
                            end else if (it.kind == 1) begin
                                chk("dload", dload[c], it.data);
                                if (it.hit) begin
                                    chk("c2c_strobe", 32'({ramREN, ramWEN}), 32'd1);
                                    chk("c2c_store", ramstore, it.data);
                                end else begin
                                    chk("rd_strobe", 32'({ramREN, ramWEN}), 32'd2);
                                end
                            end else begin
                                chk("wb_strobe", 32'({ramREN, ramWEN}), 32'd1);
                                chk("wb_store", ramstore, it.data);
                            end
                            if (it.lat >= 0) begin
                                chk("latency", 32'(cyc - it.t0), 32'(it.lat));
                            end
                            ack_cnt[c]++;
                        end
                    end
                end
            end
        end
    end

    // One clock: RAM write commit, ramstate, request drop after ack
    task automatic step();
        bit          wr;
        logic [31:0] wa, wd;
        @(negedge CLK);
        wr = ramWEN && (ramstate == RS_ACC);
        wa = ramaddr;
        wd = ramstore;
        @(posedge CLK);
        #1;
        if (wr) ram[wa[7:2]] = wd;
        if (busy_left > 0) begin
            ramstate = RS_BUSY;
            busy_left--;
        end else if (rand_ram && $urandom_range(0, 1) == 0) begin
            ramstate = 2'($urandom_range(0, 3));
        end else begin
            ramstate = RS_ACC;
        end
        for (int c = 0; c < 2; c++) begin
            if (ack_cnt[c] != seen[c]) begin
                seen[c] = ack_cnt[c];
                iREN[c] = 1'b0;
                dREN[c] = 1'b0;
                dWEN[c] = 1'b0;
            end
        end
    endtask

    // op: 0 none, 1 ifetch, 2 read, 3 write (higher number wins)
    task automatic issue(input int op0, input int op1,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [1:0] h, input logic [31:0] sv0,
                         input logic [31:0] sv1, input logic [1:0] itn,
                         input logic [1:0] tr, input int lat);
        int          op[2];
        logic [31:0] a[2];
        logic [31:0] d[2];
        logic [31:0] sv[2];
        bit          pend[2];
        int          g, cls;
        bit          first;
        item_t       x;
        op = '{op0, op1};
        a  = '{a0, a1};
        d  = '{d0, d1};
        sv = '{sv0, sv1};
        first = 1'b1;
        hit = h;
        intent = itn;
        cctrans = tr;
        for (int c = 0; c < 2; c++) begin
            snoopval[c] = sv[c];
            wdata[c]    = d[c];
            iaddr[c]    = a[c];
            daddr[c]    = a[c];
            pend[c]     = (op[c] != 0);
        end
        while (pend[0] || pend[1]) begin
            cls = 0;
            for (int c = 0; c < 2; c++)
                if (pend[c] && op[c] > cls) cls = op[c];
            if (pend[0] && op[0] == cls && pend[1] && op[1] == cls) g = 1 - rr_m;
            else if (pend[1] && op[1] == cls) g = 1;
            else g = 0;
            rr_m = g;
            x.core = g;
            x.kind = cls - 1;
            x.addr = a[g];
            x.hit  = 1'b0;
            x.inv  = 1'b0;
            x.lat  = first ? lat : -1;
            x.t0   = cyc;
            first  = 1'b0;
            if (cls == 3) begin
                refmem[a[g][7:2]] = d[g];
                x.data = d[g];
            end else if (cls == 2) begin
                x.inv = tr[g] & itn[g];
                x.hit = h[1 - g];
                if (x.hit) begin
                    x.data = sv[1 - g];
                    refmem[a[g][7:2]] = sv[1 - g];
                end else begin
                    x.data = refmem[a[g][7:2]];
                end
            end else begin
                x.data = refmem[a[g][7:2]];
            end
            exq.push_back(x);
            pend[g] = 1'b0;
        end
        for (int c = 0; c < 2; c++) begin
            iREN[c] = (op[c] == 1);
            dREN[c] = (op[c] == 2);
            dWEN[c] = (op[c] == 3);
        end
    endtask

    task automatic wait_round();
        int n;
        n = 0;
        while ((exq.size() != 0 || (iREN | dREN | dWEN) != 0) && n < 400) begin
            step();
            n++;
        end
        chk("round_done", 32'(exq.size()) + 32'($countones({iREN, dREN, dWEN})), 32'd0);
        exq.delete();
        iREN = '0;
        dREN = '0;
        dWEN = '0;
        hit = '0;
        intent = '0;
        cctrans = '0;
        step();
    endtask

    initial begin
        int n;
        nRST = 1'b0;
        iREN = '0; dREN = '0; dWEN = '0; cctrans = '0;
        iaddr = '0; daddr = '0; hit = '0; intent = '0;
        snoopval = '0; wdata = '0;
        ramstate = RS_ACC;
        for (int i = 0; i < 64; i++) begin
            ram[i] = 32'hA5000000 + 32'(i);
            refmem[i] = 32'hA5000000 + 32'(i);
        end
        ram[16] = 32'h8C010004;
        refmem[16] = 32'h8C010004;
        #1;
        chk("rst_iwait", 32'(iwait), 32'd3);
        chk("rst_dwait", 32'(dwait), 32'd3);
        chk("rst_ccwait", 32'({ccwait, ccinv}), 32'd0);
        chk("rst_strobes", 32'({ramREN, ramWEN}), 32'd0);
        chk("rst_ramaddr", ramaddr | ramstore, 32'd0);
        chk("rst_loads", iload[0] | iload[1] | dload[0] | dload[1], 32'd0);
        step();
        step();
        nRST = 1'b1;
        step();

        issue(1, 0, 32'h40, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 2);
        wait_round();
        issue(0, 2, 0, 32'h100, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 3);
        wait_round();
        issue(2, 0, 32'h200, 0, 0, 0, 2'b10, 0, 32'hDEADBEEF, 2'b01, 2'b01, 3);
        wait_round();

        nRST = 1'b0;
        step();
        nRST = 1'b1;
        rr_m = 1;
        step();
        issue(3, 3, 32'h10, 32'h14, 32'h11110000, 32'h22220000,
              2'b00, 0, 0, 2'b00, 2'b00, 2);
        wait_round();
        issue(3, 3, 32'h18, 32'h1C, 32'h33330000, 32'h44440000,
              2'b00, 0, 0, 2'b00, 2'b00, 2);
        wait_round();

        busy_left = 4;
        issue(3, 1, 32'h20, 32'h20, 32'h12345678, 0,
              2'b00, 0, 0, 2'b00, 2'b00, 5);
        wait_round();

        busy_left = 10;
        daddr[0] = 32'h30;
        wdata[0] = 32'hBADBAD00;
        dWEN[0] = 1'b1;
        rr_m = 0;
        step();
        step();
        step();
        chk("abort_pre_strobe", 32'(ramWEN), 32'd1);
        dWEN[0] = 1'b0;
        #1;
        chk("abort_strobe", 32'({ramREN, ramWEN}), 32'd0);
        chk("abort_dwait", 32'(dwait), 32'd3);
        step();
        chk("abort_idle", 32'({ramREN, ramWEN, ccwait}), 32'd0);
        busy_left = 0;
        step();

        busy_left = 30;
        issue(0, 2, 0, 32'h104, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, -1);
        n = 0;
        while (!ramREN && n < 20) begin
            step();
            n++;
        end
        chk("reached_ramrd", 32'(ramREN), 32'd1);
        #3;
        nRST = 1'b0;
        #1;
        chk("midrst_strobe", 32'({ramREN, ramWEN}), 32'd0);
        chk("midrst_wait", 32'({iwait, dwait}), 32'hF);
        chk("midrst_cc", 32'({ccwait, ccinv}), 32'd0);
        chk("midrst_addr", ramaddr, 32'd0);
        step();
        step();
        busy_left = 0;
        rr_m = 1;
        nRST = 1'b1;
        wait_round();

        rand_ram = 1'b1;
        repeat (40) begin
            int o0, o1;
            o0 = $urandom_range(0, 3);
            o1 = $urandom_range(0, 3);
            if (o0 == 0 && o1 == 0) o0 = 3;
            issue(o0, o1,
                  32'($urandom_range(0, 63)) << 2,
                  32'($urandom_range(0, 63)) << 2,
                  $urandom, $urandom,
                  2'($urandom_range(0, 3)), $urandom, $urandom,
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), -1);
            wait_round();
        end
        rand_ram = 1'b0;
        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
